// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared widths and the packer state type for the receive block assembler.
// Also holds a helper that drops one 32-bit word into its big-endian slot of a
// 128-bit block (word 0 lands in the most significant 32 bits).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    // The state encoding doubles as the count of words held in the partial block.
    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2,
        W3 = 2'd3
    } pack_state_e;

    // Insert a word into the slot selected by the packer state.
    function automatic logic [BLOCK_W-1:0] place_word(
        input logic [BLOCK_W-1:0] blk,
        input pack_state_e        slot,
        input logic [WORD_W-1:0]  word
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        case (slot)
            W0:      r[127:96] = word;
            W1:      r[95:64]  = word;
            W2:      r[63:32]  = word;
            W3:      r[31:0]   = word;
            default: r         = blk;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rcv_block_assembler_block_fifo.sv
// -----------------------------------------------------------------------------
// block_fifo
// DEPTH x 128-bit show-ahead FIFO for completed receive blocks.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   flush_i       : empty the FIFO (pointers and occupancy to zero)
//   enq_i         : write enq_data_i at the tail (ignored when full)
//   enq_data_i    : 128-bit block to store
//   deq_i         : pop the head entry (ignored when empty)
//   head_o        : registered head entry; holds its last value when empty
//   empty_o/full_o: registered occupancy flags
// -----------------------------------------------------------------------------
module block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               enq_i,
    input  logic [BLOCK_W-1:0] enq_data_i,
    input  logic               deq_i,
    output logic [BLOCK_W-1:0] head_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [BLOCK_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [BLOCK_W-1:0] head_q,   head_d;
    logic               empty_q,  full_q;
    logic               do_enq_s, do_deq_s;

    assign do_enq_s = enq_i && !full_q && !flush_i;
    assign do_deq_s = deq_i && !empty_q && !flush_i;

    // Block storage; contents are don't-care until written so no reset.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

    // Next pointers, occupancy and head value.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            head_d   = head_q;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_enq_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_deq_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_enq_s, do_deq_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // The new head may be the entry being written this same edge
            // (enqueue into empty, or enqueue+dequeue at occupancy 1).
            if (count_d != {CNT_W{1'b0}}) begin
                if (do_enq_s && (wr_ptr_q == rd_ptr_d)) begin
                    head_d = enq_data_i;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end else begin
                head_d = head_q;
            end
        end
    end

    // Pointer, occupancy, head and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {BLOCK_W{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= (count_d == {CNT_W{1'b0}});
            full_q   <= (count_d == DEPTH_C);
        end
    end

    assign head_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/rcv_block_assembler.sv
// -----------------------------------------------------------------------------
// rcv_block_assembler
// Packs 32-bit words from the bus slave into 128-bit blocks (big-endian, word 0
// in [127:96]) and queues completed blocks in a DEPTH-entry show-ahead FIFO.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   word_in/valid/ready : word input handshake
//   flush             : drop the partial block and all stored blocks
//   fix_error         : clear framing_error
//   rcv_deq           : pop the head block
//   rcv_fifo_out      : head block
//   rcv_fifo_empty/full : FIFO occupancy flags
//   framing_error     : sticky error (dropped word, deq on empty, flush mid-block)
//   word_count        : words held in the partial block
// -----------------------------------------------------------------------------
module rcv_block_assembler
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               flush,
    input  logic               fix_error,
    input  logic               rcv_deq,
    output logic [BLOCK_W-1:0] rcv_fifo_out,
    output logic               rcv_fifo_empty,
    output logic               rcv_fifo_full,
    output logic               framing_error,
    output logic [1:0]         word_count
);

    pack_state_e        state_q, state_d;
    logic [BLOCK_W-1:0] partial_q, partial_d;
    logic               framing_error_q, framing_error_d;

    logic               accept_s;
    logic               enq_s;
    logic               deq_s;
    logic [BLOCK_W-1:0] enq_data_s;
    logic               word_err_s;
    logic               deq_err_s;
    logic               flush_err_s;

    // Only the last word of a block needs FIFO space; the full flag is the
    // registered one, so a same-cycle dequeue cannot make room.
    assign word_ready = !((state_q == W3) && rcv_fifo_full);
    assign accept_s   = word_valid && word_ready;

    // Packer next state, FIFO requests and error events.
    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        word_err_s  = 1'b0;
        deq_err_s   = 1'b0;
        flush_err_s = 1'b0;
        enq_data_s  = place_word(partial_q, W3, word_in);
        if (flush) begin
            state_d     = W0;
            partial_d   = {BLOCK_W{1'b0}};
            flush_err_s = (state_q != W0);
        end else begin
            if (accept_s) begin
                partial_d = place_word(partial_q, state_q, word_in);
                case (state_q)
                    W0:      state_d = W1;
                    W1:      state_d = W2;
                    W2:      state_d = W3;
                    W3: begin
                        state_d = W0;
                        enq_s   = 1'b1;
                    end
                    default: state_d = W0;
                endcase
            end else if (word_valid) begin
                word_err_s = 1'b1;
            end else begin
                word_err_s = 1'b0;
            end
            if (rcv_deq) begin
                if (!rcv_fifo_empty) begin
                    deq_s = 1'b1;
                end else begin
                    deq_err_s = 1'b1;
                end
            end else begin
                deq_s = 1'b0;
            end
        end
    end

    // Sticky error flag: a new error event wins over fix_error.
    always_comb begin
        if (word_err_s || deq_err_s || flush_err_s) begin
            framing_error_d = 1'b1;
        end else if (fix_error) begin
            framing_error_d = 1'b0;
        end else begin
            framing_error_d = framing_error_q;
        end
    end

    // Packer state, partial block and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= W0;
            partial_q       <= {BLOCK_W{1'b0}};
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            partial_q       <= partial_d;
            framing_error_q <= framing_error_d;
        end
    end

    block_fifo #(
        .DEPTH (DEPTH)
    ) u_block_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .enq_i      (enq_s),
        .enq_data_i (enq_data_s),
        .deq_i      (deq_s),
        .head_o     (rcv_fifo_out),
        .empty_o    (rcv_fifo_empty),
        .full_o     (rcv_fifo_full)
    );

    assign framing_error = framing_error_q;
    assign word_count    = state_q;

endmodule

// File: tb/tb_rcv_block_assembler.sv
module tb_rcv_block_assembler;

    logic         clk;
    logic         reset;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic         flush;
    logic         fix_error;
    logic         rcv_deq;
    logic [127:0] rcv_fifo_out;
    logic         rcv_fifo_empty;
    logic         rcv_fifo_full;
    logic         framing_error;
    logic [1:0]   word_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rcv_block_assembler #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .flush          (flush),
        .fix_error      (fix_error),
        .rcv_deq        (rcv_deq),
        .rcv_fifo_out   (rcv_fifo_out),
        .rcv_fifo_empty (rcv_fifo_empty),
        .rcv_fifo_full  (rcv_fifo_full),
        .framing_error  (framing_error),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Word j of test block k.
    function automatic logic [31:0] mk_word(input logic [7:0] k, input int j);
        logic [7:0] jj;
        jj = 8'(j);
        return {k, jj, 16'hC0DE};
    endfunction

    function automatic logic [127:0] exp_blk(input logic [7:0] k);
        return {mk_word(k, 0), mk_word(k, 1), mk_word(k, 2), mk_word(k, 3)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input logic deq);
        word_in    = w;
        word_valid = 1'b1;
        rcv_deq    = deq;
        cyc();
        word_valid = 1'b0;
        rcv_deq    = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] k, input logic deq_last);
        for (int j = 0; j < 4; j++) begin
            push_word(mk_word(k, j), (j == 3) && deq_last);
        end
    endtask

    task automatic pulse_deq();
        rcv_deq = 1'b1;
        cyc();
        rcv_deq = 1'b0;
    endtask

    task automatic pulse_fix();
        fix_error = 1'b1;
        cyc();
        fix_error = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; word_in = 32'h0; word_valid = 1'b0;
        flush = 1'b0; fix_error = 1'b0; rcv_deq = 1'b0;
        repeat (2) cyc();
        // Reset state
        chk("rst_empty", rcv_fifo_empty, 1'b1);
        chk("rst_full",  rcv_fifo_full,  1'b0);
        chk("rst_ferr",  framing_error,  1'b0);
        chk("rst_wc",    word_count,     2'd0);
        chk("rst_out",   rcv_fifo_out,   128'h0);
        chk("rst_ready", word_ready,     1'b1);
        reset = 1'b0;
        cyc();

        // Basic block assembly, big-endian packing
        push_word(32'h00112233, 1'b0);
        push_word(32'h44556677, 1'b0);
        chk("t1_wc2", word_count, 2'd2);
        push_word(32'h8899AABB, 1'b0);
        chk("t1_empty_w3", rcv_fifo_empty, 1'b1);
        push_word(32'hCCDDEEFF, 1'b0);
        chk("t1_empty", rcv_fifo_empty, 1'b0);
        chk("t1_out",   rcv_fifo_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("t1_wc0",   word_count, 2'd0);

        // Enqueue and dequeue in the same cycle at occupancy 1
        push_block(8'h10, 1'b1);
        chk("t2_empty", rcv_fifo_empty, 1'b0);
        chk("t2_out",   rcv_fifo_out, exp_blk(8'h10));
        chk("t2_ferr",  framing_error, 1'b0);
        pulse_deq();
        chk("t2_drained", rcv_fifo_empty, 1'b1);

        // Fill to full, back-pressure on the 4th word
        for (int k = 0; k < 4; k++) push_block(8'(8'h20 + k), 1'b0);
        chk("t3_full",  rcv_fifo_full, 1'b1);
        chk("t3_head0", rcv_fifo_out, exp_blk(8'h20));
        for (int j = 0; j < 3; j++) push_word(mk_word(8'h30, j), 1'b0);
        chk("t3_wc3",   word_count, 2'd3);
        chk("t3_ready", word_ready, 1'b0);
        chk("t3_ferr0", framing_error, 1'b0);
        push_word(mk_word(8'h30, 3), 1'b0);
        chk("t3_drop_wc",   word_count, 2'd3);
        chk("t3_drop_ferr", framing_error, 1'b1);
        fix_error = 1'b1;
        push_word(mk_word(8'h30, 3), 1'b0);
        fix_error = 1'b0;
        chk("t3_err_prio", framing_error, 1'b1);
        pulse_fix();
        chk("t3_fix", framing_error, 1'b0);
        // Same-cycle deq does not make room for the word
        push_word(mk_word(8'h30, 3), 1'b1);
        chk("t3_dq_ferr", framing_error, 1'b1);
        chk("t3_dq_wc",   word_count, 2'd3);
        chk("t3_dq_full", rcv_fifo_full, 1'b0);
        chk("t3_dq_head", rcv_fifo_out, exp_blk(8'h21));
        pulse_fix();
        push_word(mk_word(8'h30, 3), 1'b0);
        chk("t3_refull", rcv_fifo_full, 1'b1);
        chk("t3_wc0",    word_count, 2'd0);
        pulse_deq();
        chk("t3_head2", rcv_fifo_out, exp_blk(8'h22));
        pulse_deq();
        chk("t3_head3", rcv_fifo_out, exp_blk(8'h23));
        pulse_deq();
        chk("t3_headx", rcv_fifo_out, exp_blk(8'h30));
        pulse_deq();
        chk("t3_empty", rcv_fifo_empty, 1'b1);
        chk("t3_ferr_end", framing_error, 1'b0);

        // Dequeue while empty
        pulse_deq();
        chk("t4_ferr",  framing_error, 1'b1);
        chk("t4_empty", rcv_fifo_empty, 1'b1);
        pulse_fix();
        push_block(8'h40, 1'b0);
        chk("t4_head", rcv_fifo_out, exp_blk(8'h40));

        // Flush mid-block with a stored block; same-cycle word and deq ignored
        push_word(mk_word(8'h50, 0), 1'b0);
        push_word(mk_word(8'h50, 1), 1'b0);
        flush = 1'b1; word_valid = 1'b1; word_in = 32'hDEADBEEF; rcv_deq = 1'b1;
        cyc();
        flush = 1'b0; word_valid = 1'b0; rcv_deq = 1'b0;
        chk("t5_wc",    word_count, 2'd0);
        chk("t5_empty", rcv_fifo_empty, 1'b1);
        chk("t5_ferr",  framing_error, 1'b1);
        pulse_fix();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t5_flush_idle_ferr", framing_error, 1'b0);

        // Stream 9 blocks with interleaved deq: pointers wrap, order kept
        for (int k = 0; k < 9; k++) begin
            push_block(8'(8'h60 + k), k >= 2);
            chk($sformatf("t6_head%0d", k), rcv_fifo_out,
                exp_blk(8'(8'h60 + ((k >= 2) ? k - 1 : 0))));
        end
        pulse_deq();
        chk("t6_last", rcv_fifo_out, exp_blk(8'h68));
        pulse_deq();
        chk("t6_empty", rcv_fifo_empty, 1'b1);
        chk("t6_ferr",  framing_error, 1'b0);

        // Reset mid-block after an error
        pulse_deq();
        push_word(mk_word(8'h70, 0), 1'b0);
        push_word(mk_word(8'h70, 1), 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t7_wc",    word_count, 2'd0);
        chk("t7_ferr",  framing_error, 1'b0);
        chk("t7_empty", rcv_fifo_empty, 1'b1);
        chk("t7_out",   rcv_fifo_out, 128'h0);
        push_block(8'h80, 1'b0);
        chk("t7_fresh", rcv_fifo_out, exp_blk(8'h80));
        chk("t7_ferr2", framing_error, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rcv_block_assembler.md
RCV_BLOCK_ASSEMBLER -- requirements
Module: rcv_block_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 128-bit block entries held (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port word_in  input  32  data word written by the AHB slave.
REQ-005 SHALL have port word_valid  input  1  word_in valid this cycle.
REQ-006 SHALL have port word_ready  output  1  word accepted when word_valid && word_ready.
REQ-007 SHALL have port flush  input  1  discard partial block and all stored blocks.
REQ-008 SHALL have port fix_error  input  1  clears framing_error.
REQ-009 SHALL have port rcv_deq  input  1  consumer pops head block.
REQ-010 SHALL have port rcv_fifo_out  output  128  head block, show-ahead.
REQ-011 SHALL have port rcv_fifo_empty  output  1  no complete block stored.
REQ-012 SHALL have port rcv_fifo_full  output  1  DEPTH blocks stored.
REQ-013 SHALL have port framing_error  output  1  sticky error flag.
REQ-014 SHALL have port word_count  output  2  words held in partial block (0..3).

Function
REQ-015 SHALL pack words big-endian: word 0 into [127:96], word 1 [95:64], word 2 [63:32], word 3 [31:0].
REQ-016 SHALL implement packer states W0, W1, W2, W3 (word_count value); accepted word advances W0->W1->W2->W3->W0.
REQ-017 SHALL, on accepting the word in W3, write the completed 128-bit block to the FIFO tail that same edge; rcv_fifo_empty deasserts the next cycle (latency 1 cycle from 4th word).
REQ-018 SHALL drive word_ready = !(state==W3 && rcv_fifo_full); words in W0..W2 are always accepted.
REQ-019 SHALL, when word_valid && !word_ready, drop the word, hold state, and set framing_error.
REQ-020 SHALL present rcv_fifo_out = head entry whenever !rcv_fifo_empty; value undefined-but-stable (hold last) when empty.
REQ-021 SHALL, on rcv_deq && !rcv_fifo_empty, advance head by one; rcv_deq when empty is ignored and sets framing_error.
REQ-022 SHALL allow simultaneous enqueue (W3 completion) and dequeue in one cycle when not full: occupancy unchanged, both effective.
REQ-023 SHALL, when full, not allow same-cycle dequeue to free space for an enqueue (word_ready depends only on registered full).
REQ-024 SHALL wrap read and write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 SHALL, on flush, return to W0, empty the FIFO, ignore same-cycle word_valid and rcv_deq; set framing_error if word_count != 0.
REQ-026 SHALL clear framing_error on fix_error; a same-cycle new error event takes priority (flag stays set).
REQ-027 SHALL keep rcv_fifo_full = (occupancy == DEPTH), rcv_fifo_empty = (occupancy == 0), both registered-derived.

Reset
REQ-028 SHALL, on reset, set state W0, pointers and occupancy 0, framing_error 0, rcv_fifo_empty 1, rcv_fifo_full 0, word_count 0, rcv_fifo_out 0.
REQ-029 SHALL, on reset mid-block, discard the partial block without setting framing_error.
REQ-030 SHALL not require reset of FIFO storage array contents.

Structure
REQ-031 SHALL take BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4 and the packer state enum from shared package aes_pkg.
REQ-032 SHALL instantiate sub-module block_fifo (parameterised DEPTH x 128 storage, pointers, full/empty); packer logic stays in rcv_block_assembler.

Verification
REQ-033 SHALL cover: reset, write 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF -> next cycle rcv_fifo_empty=0, rcv_fifo_out=0x00112233_44556677_8899AABB_CCDDEEFF.
REQ-034 SHALL cover: fill 4 blocks (DEPTH=4) plus 3 words -> rcv_fifo_full=1, word_count=3, word_ready=0; 4th word dropped, framing_error=1; fix_error -> framing_error=0.
REQ-035 SHALL cover: with 1 block stored and W3, 4th word and rcv_deq same cycle -> occupancy stays 1, rcv_fifo_out equals second block.
REQ-036 SHALL cover: 2 words written then flush -> word_count=0, rcv_fifo_empty=1, framing_error=1.
REQ-037 SHALL cover: rcv_deq while empty -> no pointer change, framing_error=1; 9 blocks streamed with interleaved deq -> pointer wrap, data order preserved.
REQ-038 SHALL cover: reset asserted after 2 words -> word_count=0, framing_error=0, next 4 words form a fresh block.
